// File: rtl/analog_to_digital.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | analog_to_digital : SPI master receiver for a 12-bit serial ADC frame    |
// | Optional macro ADC_AUTO_TRIGGER_EN: free-running conversions.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module analog_to_digital #(
  parameter int CLK_DIV_HALF = 50,
  parameter int FRAME_BITS   = 16,
  parameter int DATA_BITS    = 12,
  parameter int QUIET_CYCLES = 50
) (
  input  logic                 clk_100MHz,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 spi_miso,
  output logic                 spi_cs,
  output logic                 spi_sck,
  output logic [DATA_BITS-1:0] value_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } state_t;

  localparam int              BW           = $clog2(FRAME_BITS) + 1;
  localparam logic [7:0]      C_HALF_LAST  = 8'(CLK_DIV_HALF - 1);
  localparam logic [15:0]     C_QUIET_LAST = 16'(QUIET_CYCLES - 1);
  localparam logic [BW-1:0]   C_BIT_LAST   = BW'(FRAME_BITS - 1);

  state_t                 state_q;
  logic [7:0]             cnt_q;
  logic [BW-1:0]          bit_q;
  logic [15:0]            qcnt_q;
  logic [FRAME_BITS-1:0]  shreg_q;
  logic [FRAME_BITS-1:0]  shreg_d;
  logic [DATA_BITS-1:0]   value_q;
  logic                   cs_q, sck_q, valid_q, err_q, busy_q;
  logic                   go_d;
  logic                   half_end_d;

`ifdef ADC_AUTO_TRIGGER_EN
  logic unused_start;
  assign unused_start = start;
  assign go_d         = 1'b1;
`else
  assign go_d         = start;
`endif

  assign shreg_d    = {shreg_q[FRAME_BITS-2:0], spi_miso};
  assign half_end_d = (cnt_q == C_HALF_LAST);

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      qcnt_q  <= '0;
      shreg_q <= '0;
      value_q <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cs_q  <= 1'b1;
          sck_q <= 1'b1;
          if (go_d) begin
            state_q <= SETUP;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        SETUP: begin
          if (half_end_d) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SHIFT: begin
          if (!half_end_d) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= '0;
            // Sample MISO on the same edge that raises SCK.
            if (!sck_q) begin
              sck_q   <= 1'b1;
              shreg_q <= shreg_d;
            end else if (bit_q == C_BIT_LAST) begin
              state_q <= QUIET;
              cs_q    <= 1'b1;
              qcnt_q  <= '0;
              value_q <= shreg_q[DATA_BITS-1:0];
              err_q   <= |shreg_q[FRAME_BITS-1:DATA_BITS];
              valid_q <= 1'b1;
            end else begin
              sck_q <= 1'b0;
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        QUIET: begin
          if (qcnt_q == C_QUIET_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            qcnt_q <= qcnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_cs     = cs_q;
  assign spi_sck    = sck_q;
  assign value_out  = value_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire
